seq_divider_24: RTL and testbench
=================================

Name: seq_divider_24

Overview:
Sequential signed integer divider for the arithmetic datapath; the inverse of the radix-4 multiplier, computing quotient and remainder of two's-complement operands.
- Radix-2 non-restoring iteration, one quotient bit per clock, built around an add/subtract step.
- Fixed latency, start/valid handshake.
- Results truncate toward zero: remainder takes the sign of the dividend.

Parameters:
WIDTH, 24, operand/result width in bits (≥4)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request; accepted only when ready=1
dividend  in  WIDTH  signed dividend, sampled on accept edge
divisor  in  WIDTH  signed divisor, sampled on accept edge
ready  out  1  high when a start will be accepted
out_valid  out  1  one-cycle pulse, results valid
quotient  out  WIDTH  signed quotient
remainder  out  WIDTH  signed remainder
div_by_zero  out  1  divisor was 0 (valid with out_valid)
overflow  out  1  quotient unrepresentable (valid with out_valid)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
- A rst asserted mid-operation abandons the operation; no out_valid is produced.
- States: IDLE -> DIV -> FIX -> IDLE.
- IDLE, start=1 on edge k:
  - Register |dividend|, |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend), zero and overflow flags.
  - Clear partial remainder (WIDTH+1 bits, signed); count=0; go to DIV.
- DIV, edges k+1..k+WIDTH:
  - Shift {R,Q} left one bit.
  - If R≥0, R -= |divisor|; else R += |divisor|.
  - New Q LSB = ~R_new sign.
  - Increment count; leave DIV after WIDTH iterations.
- FIX, edge k+WIDTH+1:
  - If R<0, R += |divisor|.
  - Apply signs: quotient negated if sign_q; remainder negated if sign_r and R≠0.
  - Register outputs; out_valid=1 in the following cycle only.
  - State returns to IDLE on the same edge.
- Latency: out_valid is high in the cycle beginning WIDTH+2 edges after the accept edge (26 cycles for WIDTH=24).
- ready=1 exactly when state=IDLE, including the out_valid cycle, so back-to-back issue gives one result every WIDTH+2 cycles.
- start while ready=0: ignored, no side effects.
- Outputs hold their last values until the next FIX edge or rst.
- Divisor=0:
  - Iteration runs with the same latency.
  - FIX forces quotient = all ones (-1), remainder = dividend, div_by_zero=1, overflow=0.
- dividend = -2^(WIDTH-1) and divisor = -1: quotient = -2^(WIDTH-1) (wrapped), remainder=0, overflow=1.
- In all other cases div_by_zero=0 and overflow=0.
- Absolute value of -2^(WIDTH-1) is handled as an unsigned WIDTH-bit magnitude; internal magnitudes are unsigned WIDTH bits, R is WIDTH+1 bits.

Optional Feature:
- Macro SEQ_DIV_ZERO_FASTPATH_EN.
- Defined: a divisor of 0 at accept skips DIV.
  - FIX executes on edge k+1; out_valid is high 2 cycles after the accept edge.
  - Results are the same as in the divide-by-zero case above.
  - All other operations are unchanged.
- Undefined: fixed WIDTH+2 latency for every operation.

Decomposition:
- Package div_pkg:
  - State enum {IDLE, DIV, FIX}.
  - Default WIDTH constant.
  - Function for two's-complement magnitude/negate.
- Sub-module div_addsub: WIDTH+1-bit combinational add/subtract step.
  - Inputs: shifted R, |divisor|, op.
  - Output: R_new.
  - Reused in FIX for the restoring add.
- The top level holds the FSM, counter and registers.

Test Plan (WIDTH=24):
- Unsigned-range divide: start with 100 / 7 -> quotient=14, remainder=2, flags 0; out_valid exactly 26 cycles after the accept edge.
- Sign combinations:
  - -100 / 7 -> quotient=-14, remainder=-2.
  - 100 / -7 -> quotient=-14, remainder=2.
  - -100 / -7 -> quotient=14, remainder=-2.
- Divide by zero: 55 / 0 -> quotient=24'hFFFFFF, remainder=55, div_by_zero=1; latency 26 without the macro, 2 with SEQ_DIV_ZERO_FASTPATH_EN.
- Overflow: 24'h800000 / 24'hFFFFFF -> quotient=24'h800000, remainder=0, overflow=1.
- Handshake:
  - start pulsed at cycle 5 of an operation is ignored; the result matches the first operands.
  - start held high in the out_valid cycle with 1000 / 10 -> accepted; next out_valid 26 cycles later with quotient=100, remainder=0.
- Reset mid-operation: rst at cycle 10 after accept -> next cycle all outputs 0 and ready=1, no out_valid; a subsequent 9 / 2 gives quotient=4, remainder=1.

Source files
------------

// File: rtl/seq_divider_24_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int MAXW      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Two's-complement negate when neg is set; callers keep only the low bits they need.
  function automatic logic [MAXW-1:0] cond_neg(input logic [MAXW-1:0] x, input logic neg);
    return neg ? (~x + MAXW'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_divider_24_if.sv
// Start/valid handshake and operand/result bus of the divider.
interface seq_divider_24_if #(parameter int WIDTH = div_pkg::DEF_WIDTH);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             out_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_24_addsub.sv
// Combinational add/subtract step for the partial remainder.
module div_addsub
  import div_pkg::*;
#(
  parameter int W = DEF_WIDTH + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          op,
  output logic [W-1:0] y
);

  // y = a - b for OP_SUB, a + b for OP_ADD
  always_comb begin
    y = (op == OP_SUB) ? (a - b) : (a + b);
  end

endmodule

// File: rtl/seq_divider_24.sv
// Sequential signed divider, radix-2 non-restoring, WIDTH+2 cycle latency.
// Optional macro SEQ_DIV_ZERO_FASTPATH_EN: a zero divisor skips the DIV phase.
module seq_divider_24
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic              clk,
  input logic              rst,
  seq_divider_24_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state, state_nx;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic             sign_q, sign_r, dz, ov;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] dvd_mag, dvs_mag, rem_mag, q_signed, r_signed;
  logic [WIDTH:0]   as_a, as_y;
  op_e              as_op;
  logic             accept;

  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             out_valid_q, dz_q, ov_q;

  assign accept        = (state == IDLE) && bus.start;
  assign bus.ready     = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow  = ov_q;

  // Operand magnitudes; the most negative value maps to its unsigned magnitude.
  always_comb begin
    dvd_mag = WIDTH'(cond_neg(MAXW'(bus.dividend), bus.dividend[WIDTH-1]));
    dvs_mag = WIDTH'(cond_neg(MAXW'(bus.divisor), bus.divisor[WIDTH-1]));
  end

  // The single add/sub unit does the iteration step in DIV and the restoring add in FIX.
  always_comb begin
    as_a  = (state == FIX) ? r : {r[WIDTH-1:0], q[WIDTH-1]};
    as_op = (state == DIV && !r[WIDTH]) ? OP_SUB : OP_ADD;
  end

  div_addsub #(.W(WIDTH + 1)) u_addsub (
    .a  (as_a),
    .b  ({1'b0, b_mag}),
    .op (as_op),
    .y  (as_y)
  );

  // Final correction and sign application for FIX.
  always_comb begin
    rem_mag  = r[WIDTH] ? as_y[WIDTH-1:0] : r[WIDTH-1:0];
    q_signed = WIDTH'(cond_neg(MAXW'(q), sign_q));
    r_signed = WIDTH'(cond_neg(MAXW'(rem_mag), sign_r && (rem_mag != '0)));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef SEQ_DIV_ZERO_FASTPATH_EN
          state_nx = (bus.divisor == '0) ? FIX : DIV;
`else
          state_nx = DIV;
`endif
        end
      end
      DIV:     if (count == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      b_mag       <= '0;
      dvd_raw     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      count       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      out_valid_q <= (state == FIX);
      if (accept) begin
        r       <= '0;
        q       <= dvd_mag;
        b_mag   <= dvs_mag;
        dvd_raw <= bus.dividend;
        sign_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
        sign_r  <= bus.dividend[WIDTH-1];
        dz      <= (bus.divisor == '0);
        ov      <= (bus.dividend == MINV) && (bus.divisor == '1);
        count   <= '0;
      end else if (state == DIV) begin
        r     <= as_y;
        q     <= {q[WIDTH-2:0], ~as_y[WIDTH]};
        count <= count + CW'(1);
      end else if (state == FIX) begin
        if (dz) begin
          quotient_q  <= '1;
          remainder_q <= dvd_raw;
          dz_q        <= 1'b1;
          ov_q        <= 1'b0;
        end else begin
          quotient_q  <= q_signed;
          remainder_q <= r_signed;
          dz_q        <= 1'b0;
          ov_q        <= ov;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_24.sv
// Directed self-checking bench for seq_divider_24 (WIDTH=24).
module tb_seq_divider_24;
  import div_pkg::*;

  localparam int W = 24;
`ifdef SEQ_DIV_ZERO_FASTPATH_EN
  localparam int LAT_DZ = 2;
`else
  localparam int LAT_DZ = 26;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   lat;
  int   stray;

  seq_divider_24_if #(.WIDTH(W)) bus ();

  seq_divider_24 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present operands at a negedge; the following posedge is the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    chk("ready_at_issue", 64'(bus.ready), 64'd1);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
  endtask

  // Counts negedges after the accept edge until out_valid; lat=0 on timeout.
  task automatic wait_valid(input int glitch_at, input logic hold,
                            input logic [W-1:0] na, input logic [W-1:0] nb,
                            output int l);
    l = 0;
    for (int n = 1; n <= 40 && l == 0; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (n == glitch_at) begin
        chk("ready_busy", 64'(bus.ready), 64'd0);
        bus.start    = 1'b1;
        bus.dividend = 24'd200;
        bus.divisor  = 24'd3;
      end
      if (bus.out_valid === 1'b1) begin
        l = n;
        chk("ready_in_valid", 64'(bus.ready), 64'd1);
        if (hold) begin
          bus.start    = 1'b1;
          bus.dividend = na;
          bus.divisor  = nb;
        end
      end
    end
  endtask

  task automatic check_res(input string tag, input int l, input int el,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input logic eov);
    chk({tag, "_lat"}, 64'(l), 64'(el));
    chk({tag, "_q"},   64'(bus.quotient), 64'(eq));
    chk({tag, "_r"},   64'(bus.remainder), 64'(er));
    chk({tag, "_dz"},  64'(bus.div_by_zero), 64'(edz));
    chk({tag, "_ov"},  64'(bus.overflow), 64'(eov));
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int el, input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic edz, input logic eov);
    int l;
    issue(a, b);
    wait_valid(0, 1'b0, '0, '0, l);
    check_res(tag, l, el, eq, er, edz, eov);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_hold"},  64'(bus.quotient), 64'(eq));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_q",     64'(bus.quotient), 64'd0);
    chk("rst_r",     64'(bus.remainder), 64'd0);
    chk("rst_dz",    64'(bus.div_by_zero), 64'd0);
    chk("rst_ov",    64'(bus.overflow), 64'd0);

    run("pp", 24'd100,     24'd7,      26, 24'd14,     24'd2,      1'b0, 1'b0);
    run("np", 24'hFFFF9C,  24'd7,      26, 24'hFFFFF2, 24'hFFFFFE, 1'b0, 1'b0);
    run("pn", 24'd100,     24'hFFFFF9, 26, 24'hFFFFF2, 24'd2,      1'b0, 1'b0);
    run("nn", 24'hFFFF9C,  24'hFFFFF9, 26, 24'd14,     24'hFFFFFE, 1'b0, 1'b0);
    run("dz", 24'd55,      24'd0,  LAT_DZ, 24'hFFFFFF, 24'd55,     1'b1, 1'b0);
    run("ovf", 24'h800000, 24'hFFFFFF, 26, 24'h800000, 24'd0,      1'b0, 1'b1);
    run("big", 24'h7FFFFF, 24'd2,      26, 24'h3FFFFF, 24'd1,      1'b0, 1'b0);

    // start during DIV is ignored; start held in the valid cycle is accepted
    issue(24'd300, 24'd7);
    wait_valid(5, 1'b1, 24'd1000, 24'd10, lat);
    check_res("glitch", lat, 26, 24'd42, 24'd6, 1'b0, 1'b0);
    wait_valid(0, 1'b0, '0, '0, lat);
    check_res("b2b", lat, 26, 24'd100, 24'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_pulse", 64'(bus.out_valid), 64'd0);

    // reset in the middle of an operation
    issue(24'd100, 24'd7);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (n == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", 64'(bus.ready), 64'd1);
    chk("mrst_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_q",     64'(bus.quotient), 64'd0);
    chk("mrst_r",     64'(bus.remainder), 64'd0);
    chk("mrst_dz",    64'(bus.div_by_zero), 64'd0);
    chk("mrst_ov",    64'(bus.overflow), 64'd0);
    stray = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stray++;
    end
    chk("mrst_no_valid", 64'(stray), 64'd0);

    run("post", 24'd9, 24'd2, 26, 24'd4, 24'd1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
